// File: rtl/sram_access_pkg.sv
// Shared definitions for the SRAM access initiator.
//   width_e     : request width encodings (11 is reserved and behaves as a word)
//   state_e     : access sequencing states
//   width_bytes : number of bytes moved for a given width encoding
package sram_access_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'b00,
        WIDTH_HALF = 2'b01,
        WIDTH_WORD = 2'b10
    } width_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_SPLIT,
        RD_WAIT,
        WR_SPLIT,
        ACK
    } state_e;

    function automatic logic [2:0] width_bytes(input logic [1:0] width);
        case (width)
            WIDTH_BYTE: return 3'd1;
            WIDTH_HALF: return 3'd2;
            default:    return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/sram_lane_align.sv
// Combinational byte-lane steering for the SRAM access initiator.
//   Store side: st_offset/st_nbytes/st_wdata -> 8-bit lane mask and 64-bit
//               lane data spanning the current word and the next one.
//   Load side : {ld_hi, ld_lo} shifted down by ld_offset bytes, cut to
//               ld_nbytes and sign/zero extended into ld_rdata.
module sram_lane_align
    import sram_access_pkg::*;
(
    input  logic [1:0]  st_offset,
    input  logic [2:0]  st_nbytes,
    input  logic [31:0] st_wdata,
    output logic [7:0]  st_mask,
    output logic [63:0] st_data,
    input  logic [1:0]  ld_offset,
    input  logic [2:0]  ld_nbytes,
    input  logic        ld_signed,
    input  logic [31:0] ld_lo,
    input  logic [31:0] ld_hi,
    output logic [31:0] ld_rdata
);

    logic [3:0]  base_mask;
    logic [31:0] raw;

    always_comb begin
        // NOTE: every output of a combinational block gets a value on every
        // path (here via the case default) so no latch is inferred.
        case (st_nbytes)
            3'd1:    base_mask = 4'b0001;
            3'd2:    base_mask = 4'b0011;
            default: base_mask = 4'b1111;
        endcase
        st_mask = {4'b0000, base_mask} << st_offset;
        st_data = {32'h0, st_wdata} << {st_offset, 3'b000};

        // Bytes above n are discarded below, so junk in the unused lanes of
        // lo/hi never reaches the result.
        raw = 32'({ld_hi, ld_lo} >> {ld_offset, 3'b000});
        case (ld_nbytes)
            3'd1:    ld_rdata = {{24{ld_signed & raw[7]}}, raw[7:0]};
            3'd2:    ld_rdata = {{16{ld_signed & raw[15]}}, raw[15:0]};
            default: ld_rdata = raw;
        endcase
    end

endmodule

// File: rtl/sram_access_initiator.sv
// Initiator side of a byte-enabled single-port SRAM (1-cycle read latency).
// Turns byte/half/word loads and stores at any byte alignment into one or two
// word accesses.
//   clk, reset_n (sync, active low)
//   req_*  : request from the memory stage (valid/ready handshake)
//   rsp_*  : one-cycle response pulse with extended load data (0 for stores)
//   mem_*  : SRAM word address, write data, per-byte write enables, read data
module sram_access_initiator
    import sram_access_pkg::*;
#(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_width,
    input  logic                  req_signed,
    input  logic [ADDR_WIDTH+1:0] req_byte_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_din,
    output logic [3:0]            mem_write_en,
    input  logic [31:0]           mem_dout
);

    if (DATA_WIDTH != 32) begin : g_bad_data_width
        $error("sram_access_initiator supports DATA_WIDTH = 32 only");
    end

    state_e                state_q, state_d;
    logic [1:0]            off_q;
    logic [2:0]            nbytes_q;
    logic                  signed_q;
    logic                  split_q;
    logic [ADDR_WIDTH-1:0] addr2_q;
    logic [3:0]            be_hi_q;
    logic [31:0]           din_hi_q;
    logic [31:0]           lo_q;
    logic [31:0]           rdata_q;

    logic [1:0]            req_off;
    logic [ADDR_WIDTH-1:0] req_word;
    logic [2:0]            req_nbytes;
    logic                  req_split;
    logic                  fire;
    logic [7:0]            st_mask;
    logic [63:0]           st_data;
    logic [31:0]           ld_lo, ld_hi, ld_rdata;

    assign req_off    = req_byte_addr[1:0];
    assign req_word   = req_byte_addr[ADDR_WIDTH+1:2];
    assign req_nbytes = width_bytes(req_width);
    assign req_split  = ({1'b0, req_off} + req_nbytes) > 3'd4;
    assign fire       = req_valid && req_ready;

    // For a split load the first word was parked in lo_q and the second word
    // is on mem_dout now; an aligned load lives entirely in mem_dout.
    assign ld_lo = split_q ? lo_q : mem_dout;
    assign ld_hi = split_q ? mem_dout : 32'h0;

    sram_lane_align u_lane_align (
        .st_offset (req_off),
        .st_nbytes (req_nbytes),
        .st_wdata  (req_wdata),
        .st_mask   (st_mask),
        .st_data   (st_data),
        .ld_offset (off_q),
        .ld_nbytes (nbytes_q),
        .ld_signed (signed_q),
        .ld_lo     (ld_lo),
        .ld_hi     (ld_hi),
        .ld_rdata  (ld_rdata)
    );

    always_comb begin
        state_d      = state_q;
        req_ready    = 1'b0;
        mem_addr     = '0;
        mem_din      = 32'h0;
        mem_write_en = 4'b0000;
        // While reset is low nothing is accepted or driven, so a pending
        // second write is dropped in the very cycle reset appears.
        if (reset_n) begin
            case (state_q)
                IDLE: begin
                    req_ready = 1'b1;
                    if (req_valid) begin
                        mem_addr = req_word;
                        if (req_we) begin
                            mem_write_en = st_mask[3:0];
                            mem_din      = st_data[31:0];
                            state_d      = req_split ? WR_SPLIT : ACK;
                        end else begin
                            state_d      = req_split ? RD_SPLIT : RD_WAIT;
                        end
                    end
                end
                RD_SPLIT: begin
                    mem_addr = addr2_q;
                    state_d  = RD_WAIT;
                end
                WR_SPLIT: begin
                    mem_addr     = addr2_q;
                    mem_write_en = be_hi_q;
                    mem_din      = din_hi_q;
                    state_d      = ACK;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            off_q    <= 2'b00;
            nbytes_q <= 3'd0;
            signed_q <= 1'b0;
            split_q  <= 1'b0;
            addr2_q  <= '0;
            be_hi_q  <= 4'b0000;
            din_hi_q <= 32'h0;
            lo_q     <= 32'h0;
            rdata_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            if (fire) begin
                off_q    <= req_off;
                nbytes_q <= req_nbytes;
                signed_q <= req_signed;
                split_q  <= req_split;
                addr2_q  <= req_word + ADDR_WIDTH'(1);
                be_hi_q  <= st_mask[7:4];
                din_hi_q <= st_data[63:32];
            end
            if (state_q == RD_SPLIT) lo_q <= mem_dout;
            if (state_q == RD_WAIT)  rdata_q <= ld_rdata;
            if (state_q == ACK)      rdata_q <= 32'h0;
        end
    end

    // The response is decoded from the state register; in RD_WAIT the data is
    // formed straight from mem_dout and is held in rdata_q afterwards.
    assign rsp_valid = (state_q == RD_WAIT) || (state_q == ACK);
    always_comb begin
        case (state_q)
            RD_WAIT: rsp_rdata = ld_rdata;
            ACK:     rsp_rdata = 32'h0;
            default: rsp_rdata = rdata_q;
        endcase
    end

endmodule

// File: tb/tb_sram_access_initiator.sv
// Directed self-checking bench for sram_access_initiator with a small
// synchronous SRAM model (1-cycle read latency, per-byte write enables).
module tb_sram_access_initiator;

    localparam int AW = 14;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_width;
    logic          req_signed;
    logic [AW+1:0] req_byte_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_din;
    logic [3:0]    mem_write_en;
    logic [31:0]   mem_dout;

    logic [31:0]   sram [0:(1<<AW)-1];

    int checks   = 0;
    int failures = 0;

    sram_access_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_width     (req_width),
        .req_signed    (req_signed),
        .req_byte_addr (req_byte_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .mem_addr      (mem_addr),
        .mem_din       (mem_din),
        .mem_write_en  (mem_write_en),
        .mem_dout      (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (mem_write_en[b]) sram[mem_addr][8*b +: 8] <= mem_din[8*b +: 8];
        mem_dout <= sram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] width, input logic sgn,
                         input logic [AW+1:0] addr, input logic [31:0] wdata);
        req_valid     = 1'b1;
        req_we        = we;
        req_width     = width;
        req_signed    = sgn;
        req_byte_addr = addr;
        req_wdata     = wdata;
    endtask

    // Aligned word store used to set up memory contents.
    task automatic preload(input logic [AW+1:0] addr, input logic [31:0] data);
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, addr, data);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [1:0] width, input logic sgn,
                              input logic [AW+1:0] addr, input logic split,
                              input logic [31:0] expected);
        @(negedge clk);
        drive(1'b0, width, sgn, addr, 32'h0);
        #1;
        check({tag, "_we_at_T"}, {28'h0, mem_write_en}, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        if (split) begin
            #1;
            check({tag, "_no_rsp_T1"}, {31'h0, rsp_valid}, 32'h0);
            @(negedge clk);
        end
        #1;
        check({tag, "_rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
        check({tag, "_rdata"}, rsp_rdata, expected);
        @(negedge clk);
        #1;
        check({tag, "_rsp_pulse"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    int accepts;
    int rsps;

    initial begin
        reset_n       = 1'b0;
        req_valid     = 1'b0;
        req_we        = 1'b0;
        req_width     = 2'b00;
        req_signed    = 1'b0;
        req_byte_addr = '0;
        req_wdata     = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_we", {28'h0, mem_write_en}, 32'h0);
        check("rst_addr", {18'h0, mem_addr}, 32'h0);
        check("rst_din", mem_din, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rst_release_ready", {31'h0, req_ready}, 32'h1);

        // Aligned word store 0xDEADBEEF at 0x10.
        drive(1'b1, 2'b10, 1'b0, 16'h0010, 32'hDEADBEEF);
        #1;
        check("sw_addr", {18'h0, mem_addr}, 32'h4);
        check("sw_we", {28'h0, mem_write_en}, 32'hF);
        check("sw_din", mem_din, 32'hDEADBEEF);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("sw_rsp_valid", {31'h0, rsp_valid}, 32'h1);
        check("sw_rsp_rdata", rsp_rdata, 32'h0);
        check("sw_ack_ready", {31'h0, req_ready}, 32'h0);
        check("sw_ack_we", {28'h0, mem_write_en}, 32'h0);

        load_check("lw_10", 2'b10, 1'b0, 16'h0010, 1'b0, 32'hDEADBEEF);

        // Byte and half loads with extension.
        preload(16'h0010, 32'h80AABBCC);
        load_check("lb_13", 2'b00, 1'b1, 16'h0013, 1'b0, 32'hFFFFFF80);
        load_check("lbu_13", 2'b00, 1'b0, 16'h0013, 1'b0, 32'h00000080);
        load_check("lh_12", 2'b01, 1'b1, 16'h0012, 1'b0, 32'hFFFF80AA);
        load_check("lbu_11", 2'b00, 1'b0, 16'h0011, 1'b0, 32'h000000BB);

        // Split half store 0x1234 at 0x17.
        @(negedge clk);
        drive(1'b1, 2'b01, 1'b0, 16'h0017, 32'h00001234);
        #1;
        check("sh_T_addr", {18'h0, mem_addr}, 32'h5);
        check("sh_T_we", {28'h0, mem_write_en}, 32'h8);
        check("sh_T_din", mem_din, 32'h34000000);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("sh_T1_addr", {18'h0, mem_addr}, 32'h6);
        check("sh_T1_we", {28'h0, mem_write_en}, 32'h1);
        check("sh_T1_din", mem_din, 32'h00000012);
        check("sh_T1_no_rsp", {31'h0, rsp_valid}, 32'h0);
        check("sh_T1_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        #1;
        check("sh_T2_rsp", {31'h0, rsp_valid}, 32'h1);
        check("sh_T2_we", {28'h0, mem_write_en}, 32'h0);

        load_check("lhu_17", 2'b01, 1'b0, 16'h0017, 1'b1, 32'h00001234);
        check("rdata_hold", rsp_rdata, 32'h00001234);

        // Word load spanning the top word and word 0.
        preload(16'hFFFC, 32'h11223344);
        preload(16'h0000, 32'h55667788);
        @(negedge clk);
        drive(1'b0, 2'b10, 1'b0, 16'hFFFE, 32'h0);
        #1;
        check("wrap_T_addr", {18'h0, mem_addr}, 32'h3FFF);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("wrap_T1_addr", {18'h0, mem_addr}, 32'h0);
        @(negedge clk);
        #1;
        check("wrap_rsp", {31'h0, rsp_valid}, 32'h1);
        check("wrap_rdata", rsp_rdata, 32'h77881122);

        // Reset during the second half of a split store.
        preload(16'h0024, 32'h00000000);
        @(negedge clk);
        drive(1'b1, 2'b10, 1'b0, 16'h0021, 32'hCAFEF00D);
        #1;
        check("rsts_T_we", {28'h0, mem_write_en}, 32'hE);
        check("rsts_T_din", mem_din, 32'hFEF00D00);
        @(negedge clk);
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        check("rsts_T1_we", {28'h0, mem_write_en}, 32'h0);
        check("rsts_T1_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        #1;
        check("rsts_after_we", {28'h0, mem_write_en}, 32'h0);
        check("rsts_after_rsp", {31'h0, rsp_valid}, 32'h0);
        check("rsts_word9", sram[9], 32'h0);
        check("rsts_word8", {8'h0, sram[8][31:8]}, 32'h00FEF00D);
        reset_n = 1'b1;
        #1;
        check("rsts_ready", {31'h0, req_ready}, 32'h1);

        // Back-to-back aligned loads with req_valid held high.
        accepts = 0;
        rsps    = 0;
        drive(1'b0, 2'b10, 1'b0, 16'h0010, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #1;
            if (req_valid && req_ready) accepts++;
            if (rsp_valid) rsps++;
            if (c == 1) check("b2b_ready_low", {31'h0, req_ready}, 32'h0);
            if (c == 1) check("b2b_rdata", rsp_rdata, 32'h80AABBCC);
            @(negedge clk);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (rsp_valid) rsps++;
            @(negedge clk);
        end
        check("b2b_accepts", 32'(accepts), 32'd3);
        check("b2b_rsps", 32'(rsps), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_access_initiator.md
Name: sram_access_initiator

Overview:
- Initiator side of the byte-enabled single-port SRAM interface: the block that drives addr/din/write_en and consumes dout (1-cycle read latency).
- Converts CPU-style load/store requests (byte/half/word, signed/unsigned, any byte alignment) into one or two word-wide SRAM accesses.
- Handles lane shifting, byte-enable generation, misaligned splitting and sign/zero extension.
- Sits between the core's memory stage and the data SRAM bank.

Parameters:
- ADDR_WIDTH, 14, SRAM word-address width; byte address is ADDR_WIDTH+2 bits.
- DATA_WIDTH, 32, SRAM word width. Only 32 is supported; elaboration-time check fails otherwise.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_width  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved (treated as word).
- req_signed  in  1  sign-extend load result; ignored for stores and words.
- req_byte_addr  in  ADDR_WIDTH+2  byte address.
- req_wdata  in  32  store data, right-justified.
- rsp_valid  out  1  one-cycle pulse: load data valid or store complete.
- rsp_rdata  out  32  extended load data; 0 for stores.
- mem_addr  out  ADDR_WIDTH  SRAM word address.
- mem_din  out  32  SRAM write data.
- mem_write_en  out  4  SRAM per-byte write enables.
- mem_dout  in  32  SRAM read data, valid the cycle after its address.

Behaviour:
- Reset (reset_n low at a clk edge): state IDLE; rsp_valid=0; rsp_rdata=0; mem_write_en=0; mem_addr=0; mem_din=0; any pending second half is dropped. req_ready is 0 while reset_n is low.
- Accept: fire = req_valid & req_ready. req_ready=1 only in IDLE.
- Definitions: o = req_byte_addr[1:0]; w = req_byte_addr[ADDR_WIDTH+1:2]; n = number of bytes (1, 2 or 4).
- Misaligned split when o+n > 4. Second word address is w+1 and wraps from 2^ADDR_WIDTH-1 to 0.
- SRAM request signals are combinational from the request in the accept cycle.
- Second-half request signals come from registers in SPLIT states.
- mem_write_en is 0 in every cycle that is not a write access.
- Store lanes: 8-bit mask m = (1<<n)-1 shifted left by o; 64-bit data = req_wdata shifted left by 8*o.
  - First access: mem_write_en = m[3:0], mem_din = data[31:0].
  - Second access: mem_write_en = m[7:4], mem_din = data[63:32].
- Load extraction: combine {hi, lo}, shift right by 8*o, mask to n bytes, then sign- or zero-extend from bit 8n-1.
- States and timing (T = accept cycle):
  - IDLE, aligned load: mem_addr=w at T; capture o/width/signed; go RD_WAIT. rsp_valid=1 at T+1 with rsp_rdata formed from mem_dout.
  - IDLE, split load: mem_addr=w at T; go RD_SPLIT. At T+1, mem_addr=w+1, latch mem_dout as lo; go RD_WAIT. At T+2, rsp_valid with hi = mem_dout.
  - IDLE, aligned store: write at T; go ACK. rsp_valid at T+1.
  - IDLE, split store: first write at T; go WR_SPLIT. Second write at T+1; go ACK. rsp_valid at T+2.
  - RD_WAIT/ACK: return to IDLE. req_ready stays 0 in these states, so back-to-back throughput is one request per 2 cycles (aligned) or 3 cycles (split).
- rsp_valid has no backpressure and is a single-cycle pulse.
- rsp_rdata is registered and holds its value until the next response.
- Reset asserted mid-split: the second write is never issued; the first write has already been committed.

Decomposition:
- Package sram_access_pkg:
  - width encodings BYTE/HALF/WORD;
  - state enum {IDLE, RD_SPLIT, RD_WAIT, WR_SPLIT, ACK};
  - function returning n from width.
- One combinational sub-module, sram_lane_align:
  - store side: mask/data shifting to 64 bits;
  - load side: 64-bit extract plus extension.
- The FSM and registers stay in the top module.

Test Plan:
- Aligned word store 0xDEADBEEF to byte addr 0x10 (w=4) → mem_write_en=4'b1111 at T, rsp_valid at T+1. Load word from 0x10 → rsp_rdata=0xDEADBEEF at T+1.
- Signed byte load, addr 0x13, word holds 0x80AA_BBCC → rsp_rdata=0xFFFF_FF80. Same load unsigned → 0x0000_0080.
- Half store 0x1234 at addr 0x17 (o=3, split):
  - T: mem_addr=5, be=4'b1000, din[31:24]=0x34.
  - T+1: mem_addr=6, be=4'b0001, din[7:0]=0x12.
  - rsp_valid at T+2. Half load from 0x17 returns 0x00001234 at T+2.
- Word load at the top byte address 2^(ADDR_WIDTH+2)-2: second access uses mem_addr=0 (wrap). Result combines word 2^ADDR_WIDTH-1 bytes 2–3 with word 0 bytes 0–1.
- Reset pulled low in the T+1 cycle of a split store:
  - no second write;
  - mem_write_en=0 and rsp_valid=0 on the following cycle;
  - req_ready=1 once reset_n is high.
- Back-to-back requests with req_valid held high: req_ready deasserts in RD_WAIT/ACK. Exactly one rsp_valid pulse per accepted request.
